// File: rtl/life_controller_if.sv
// Control/board bundle between the Game-of-Life controller and its environment.
// master drives commands, seed and the evolved board; slave (the controller) returns state.
interface life_controller_if #(
    parameter int GEN_W = 8,
    parameter int DIV_W = 8
);
    logic             load;
    logic [63:0]      seed;
    logic             start;
    logic             stop;
    logic             pause;
    logic [DIV_W-1:0] step_div;
    logic [GEN_W-1:0] gen_limit;
    logic [63:0]      grid_next;
    logic [63:0]      grid;
    logic             running;
    logic             done;
    logic [GEN_W-1:0] gen_count;
    logic [1:0]       status;

    modport master (
        output load, seed, start, stop, pause, step_div, gen_limit, grid_next,
        input  grid, running, done, gen_count, status
    );

    modport slave (
        input  load, seed, start, stop, pause, step_div, gen_limit, grid_next,
        output grid, running, done, gen_count, status
    );
endinterface

// File: rtl/life_controller.sv
// Game-of-Life run controller: owns the 8x8 board, paces generations, detects end of run (LIFE_STABLE_DETECT_EN adds stable/extinct stop).
// Latency: first commit on the (step_div+1)th edge after start, then one commit every step_div+1 RUN cycles.
// Backpressure: none; pause level freezes the pacing divider, stop aborts, load/start ignored while running.
module life_controller #(
    parameter int GEN_W = 8,
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    life_controller_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t           state;
    logic [63:0]      grid_q;
    logic [GEN_W-1:0] gen_count_q;
    logic [GEN_W-1:0] gen_limit_q;
    logic [GEN_W-1:0] gen_inc;
    logic [DIV_W-1:0] divider;
    logic [DIV_W-1:0] step_div_q;
    logic [1:0]       status_q;
    logic [1:0]       term_status;
    logic             running_q;
    logic             done_q;
    logic             limit_hit;

    assign gen_inc   = gen_count_q + 1'b1;
    assign limit_hit = (gen_limit_q != '0) && (gen_inc == gen_limit_q);

    // Later checks override earlier ones: extinct beats stable beats limit.
    always_comb begin
        term_status = 2'b00;
        if (limit_hit) term_status = 2'b01;
`ifdef LIFE_STABLE_DETECT_EN
        if (bus.grid_next == grid_q) term_status = 2'b10;
        if (bus.grid_next == '0)     term_status = 2'b11;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            grid_q      <= '0;
            gen_count_q <= '0;
            gen_limit_q <= '0;
            divider     <= '0;
            step_div_q  <= '0;
            status_q    <= 2'b00;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.load) begin
                        grid_q      <= bus.seed;
                        gen_count_q <= '0;
                        status_q    <= 2'b00;
                        state       <= IDLE;
                        done_q      <= 1'b0;
                    end else if (bus.start) begin
                        step_div_q  <= bus.step_div;
                        gen_limit_q <= bus.gen_limit;
                        divider     <= '0;
                        gen_count_q <= '0;
                        status_q    <= 2'b00;
                        state       <= RUN;
                        running_q   <= 1'b1;
                        done_q      <= 1'b0;
                    end
                end
                RUN: begin
                    if (bus.stop) begin
                        state     <= IDLE;
                        status_q  <= 2'b00;
                        running_q <= 1'b0;
                    end else if (bus.pause) begin
                        state <= PAUSE;
                    end else if (divider == step_div_q) begin
                        grid_q  <= bus.grid_next;
                        divider <= '0;
                        if (gen_count_q != '1) gen_count_q <= gen_inc;
                        if (term_status != 2'b00) begin
                            state     <= DONE;
                            status_q  <= term_status;
                            running_q <= 1'b0;
                            done_q    <= 1'b1;
                        end
                    end else begin
                        divider <= divider + 1'b1;
                    end
                end
                PAUSE: begin
                    if (bus.stop) begin
                        state     <= IDLE;
                        status_q  <= 2'b00;
                        running_q <= 1'b0;
                    end else if (!bus.pause) begin
                        state <= RUN;
                    end
                end
                default: begin
                    state     <= IDLE;
                    running_q <= 1'b0;
                    done_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.grid      = grid_q;
    assign bus.gen_count = gen_count_q;
    assign bus.status    = status_q;
    assign bus.running   = running_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_life_controller.sv
// Directed bench for life_controller: vector table plus multi-cycle corner sequences.
// The evolve datapath is modelled here with a non-wrapping 8x8 Life rule.
module tb_life_controller;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    life_controller_if #(.GEN_W(8), .DIV_W(8)) lc_if ();

    life_controller #(.GEN_W(8), .DIV_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (lc_if)
    );

    function automatic logic [63:0] life_step(input logic [63:0] g);
        logic [63:0] n;
        int cnt, rr, cc;
        n = '0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        rr = r + dr;
                        cc = c + dc;
                        if (!(dr == 0 && dc == 0) && rr >= 0 && rr < 8 && cc >= 0 && cc < 8)
                            if (g[rr*8+cc]) cnt++;
                    end
                end
                n[r*8+c] = g[r*8+c] ? (cnt == 2 || cnt == 3) : (cnt == 3);
            end
        end
        return n;
    endfunction

    always_comb lc_if.grid_next = life_step(lc_if.grid);

    typedef struct {
        string       name;
        logic        load, start, stop, pause;
        logic [63:0] seed;
        logic [7:0]  step_div, gen_limit;
        logic [63:0] e_grid;
        logic        e_running, e_done;
        logic [7:0]  e_gen;
        logic [1:0]  e_status;
    } vec_t;

    vec_t vecs[$];
    int   tests  = 0;
    int   failed = 0;

    task automatic add_vec(input string nm, input logic ld, st, sp, ps, input logic [63:0] sd,
                           input logic [7:0] sdiv, lim, input logic [63:0] eg,
                           input logic er, ed, input logic [7:0] en, input logic [1:0] es);
        vec_t v;
        v.name = nm; v.load = ld; v.start = st; v.stop = sp; v.pause = ps;
        v.seed = sd; v.step_div = sdiv; v.gen_limit = lim;
        v.e_grid = eg; v.e_running = er; v.e_done = ed; v.e_gen = en; v.e_status = es;
        vecs.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        lc_if.load = 1'b0; lc_if.start = 1'b0; lc_if.stop = 1'b0; lc_if.pause = 1'b0;
    endtask

    task automatic check(input string nm, input logic [63:0] g, input logic r, d,
                         input logic [7:0] n, input logic [1:0] s);
        tests++;
        if (lc_if.grid !== g || lc_if.running !== r || lc_if.done !== d ||
            lc_if.gen_count !== n || lc_if.status !== s) begin
            failed++;
            $display("FAIL %s: got grid=%h running=%b done=%b gen=%0d status=%b, want grid=%h running=%b done=%b gen=%0d status=%b",
                     nm, lc_if.grid, lc_if.running, lc_if.done, lc_if.gen_count, lc_if.status,
                     g, r, d, n, s);
        end
    endtask

    task automatic do_load(input logic [63:0] sd);
        idle_inputs();
        lc_if.load = 1'b1; lc_if.seed = sd;
        tick();
        lc_if.load = 1'b0;
    endtask

    task automatic do_start(input logic [7:0] sdiv, lim);
        idle_inputs();
        lc_if.start = 1'b1; lc_if.step_div = sdiv; lc_if.gen_limit = lim;
        tick();
        lc_if.start = 1'b0;
    endtask

    task automatic do_stop();
        idle_inputs();
        lc_if.stop = 1'b1;
        tick();
        lc_if.stop = 1'b0;
    endtask

    localparam logic [63:0] BLINK_H = 64'h0E00;
    localparam logic [63:0] BLINK_V = 64'h040404;
    localparam logic [63:0] BLOCK   = 64'h060600;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        idle_inputs();
        lc_if.seed = '0; lc_if.step_div = '0; lc_if.gen_limit = '0;

        // name, load start stop pause, seed, step_div, gen_limit, exp grid, running, done, gen, status
        add_vec("load_ff",        1,0,0,0, 64'hFF, 0, 0, 64'hFF,  0,0, 0, 2'b00);
        add_vec("load_wins",      1,1,0,0, BLINK_H, 0, 0, BLINK_H, 0,0, 0, 2'b00);
        add_vec("start_lim4",     0,1,0,0, 64'h0, 0, 4, BLINK_H,  1,0, 0, 2'b00);
        add_vec("gen1",           0,0,0,0, 64'h0, 0, 0, BLINK_V,  1,0, 1, 2'b00);
        add_vec("gen2",           0,0,0,0, 64'h0, 0, 0, BLINK_H,  1,0, 2, 2'b00);
        add_vec("gen3",           0,0,0,0, 64'h0, 0, 0, BLINK_V,  1,0, 3, 2'b00);
        add_vec("gen4_done",      0,0,0,0, 64'h0, 0, 0, BLINK_H,  0,1, 4, 2'b01);
        add_vec("done_hold",      0,0,0,0, 64'h0, 0, 0, BLINK_H,  0,1, 4, 2'b01);
        add_vec("restart_div1",   0,1,0,0, 64'h0, 1, 0, BLINK_H,  1,0, 0, 2'b00);
        add_vec("div1_wait",      0,0,0,0, 64'h0, 0, 0, BLINK_H,  1,0, 0, 2'b00);
        add_vec("div1_commit",    0,0,0,0, 64'h0, 0, 0, BLINK_V,  1,0, 1, 2'b00);
        add_vec("load_ignored",   1,0,0,0, 64'hFF, 0, 0, BLINK_V, 1,0, 1, 2'b00);
        add_vec("stop_over_commit",0,0,1,0, 64'h0, 0, 0, BLINK_V, 0,0, 1, 2'b00);
        add_vec("idle_hold",      0,0,0,0, 64'h0, 0, 0, BLINK_V,  0,0, 1, 2'b00);

        tick();
        check("in_reset", 64'h0, 0, 0, 0, 2'b00);
        tick();
        reset = 1'b0;
        tick();
        check("after_reset", 64'h0, 0, 0, 0, 2'b00);

        foreach (vecs[i]) begin
            lc_if.load = vecs[i].load; lc_if.start = vecs[i].start;
            lc_if.stop = vecs[i].stop; lc_if.pause = vecs[i].pause;
            lc_if.seed = vecs[i].seed; lc_if.step_div = vecs[i].step_div;
            lc_if.gen_limit = vecs[i].gen_limit;
            tick();
            check(vecs[i].name, vecs[i].e_grid, vecs[i].e_running, vecs[i].e_done,
                  vecs[i].e_gen, vecs[i].e_status);
        end
        idle_inputs();

        // Pause mid-interval: divider sits at 2 of 3 while paused.
        do_load(BLINK_H);
        do_start(8'd3, 8'd0);
        check("p_start", BLINK_H, 1, 0, 0, 2'b00);
        tick();
        tick();
        lc_if.pause = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("p_hold%0d", k), BLINK_H, 1, 0, 0, 2'b00);
        end
        lc_if.pause = 1'b0;
        tick();
        check("p_resume", BLINK_H, 1, 0, 0, 2'b00);
        tick();
        check("p_div3", BLINK_H, 1, 0, 0, 2'b00);
        tick();
        check("p_commit", BLINK_V, 1, 0, 1, 2'b00);
        do_stop();
        check("p_stop", BLINK_V, 0, 0, 1, 2'b00);

        // Unlimited run: gen_count saturates, run continues.
        do_load(BLINK_H);
        do_start(8'd0, 8'd0);
        repeat (260) tick();
        check("saturate", BLINK_H, 1, 0, 8'hFF, 2'b00);
        do_stop();

        // Reset in the middle of a run.
        do_load(BLINK_H);
        do_start(8'd0, 8'd0);
        tick();
        tick();
        check("r_gen2", BLINK_H, 1, 0, 2, 2'b00);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("r_mid_run", 64'h0, 0, 0, 0, 2'b00);
        tick();
        check("r_after", 64'h0, 0, 0, 0, 2'b00);

        // Still life.
        do_load(BLOCK);
        do_start(8'd0, 8'd0);
        tick();
`ifdef LIFE_STABLE_DETECT_EN
        check("block_stable", BLOCK, 0, 1, 1, 2'b10);
        tick();
        check("block_hold", BLOCK, 0, 1, 1, 2'b10);
`else
        repeat (99) tick();
        check("block_runs", BLOCK, 1, 0, 100, 2'b00);
        do_stop();
`endif

        // Lone cell dies.
        do_load(64'h1);
        do_start(8'd0, 8'd0);
        tick();
`ifdef LIFE_STABLE_DETECT_EN
        check("extinct", 64'h0, 0, 1, 1, 2'b11);
`else
        check("extinct_run", 64'h0, 1, 0, 1, 2'b00);
        tick();
        check("extinct_run2", 64'h0, 1, 0, 2, 2'b00);
        do_stop();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
